// File: rtl/term_cursor_engine.sv
// -----------------------------------------------------------------------------
// term_cursor_engine
//
// CPU-side controller for the VGA text terminal. Accepts writes to four
// registers (OUT, X, Y, ATTR) and turns characters written to OUT into
// framebuffer cell writes. It also handles cursor advance, line wrap,
// control characters, hardware scrolling (row offset) and line/screen clears.
//
// Ports
//   clk     : system clock, all logic on its rising edge
//   n_rst   : asynchronous active-low reset
//   addrin  : register select (0 OUT, 1 X, 2 Y, 3 ATTR)
//   datain  : register write data
//   inen    : one-cycle write strobe, sampled only while busy = 0
//   busy    : high while a framebuffer operation is in progress
//   fbx     : framebuffer column
//   fby     : framebuffer physical row
//   fbchar  : character to store
//   fbattr  : attribute to store
//   fbreq   : framebuffer write request
//   fback   : one-cycle framebuffer write acknowledge
//   scroll  : physical row shown at logical row 0
//   curx    : cursor column
//   cury    : cursor logical row
//
// Framebuffer handshake: fbreq rises with fbx/fby/fbchar/fbattr valid and
// holds them stable until a cycle where fback = 1 is sampled; that cycle
// completes exactly one cell write and fbreq is low in the following cycle.
// fback while fbreq = 0 is ignored. Each request is raised one cycle after
// its address is loaded, so there is always a one-cycle gap between cells.
// -----------------------------------------------------------------------------
module term_cursor_engine #(
    parameter int COLS  = 80,
    parameter int ROWS  = 30,
    parameter int ATTRW = 4,
    localparam int XW   = $clog2(COLS),
    localparam int YW   = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [1:0]       addrin,
    input  logic [7:0]       datain,
    input  logic             inen,
    output logic             busy,
    output logic [XW-1:0]    fbx,
    output logic [YW-1:0]    fby,
    output logic [7:0]       fbchar,
    output logic [ATTRW-1:0] fbattr,
    output logic             fbreq,
    input  logic             fback,
    output logic [YW-1:0]    scroll,
    output logic [XW-1:0]    curx,
    output logic [YW-1:0]    cury
);

    localparam logic [XW-1:0] X_MAX  = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(ROWS - 1);
    localparam logic [YW:0]   ROWS_W = (YW + 1)'(ROWS);
    localparam logic [7:0]    X_LIM  = 8'(COLS - 1);
    localparam logic [7:0]    Y_LIM  = 8'(ROWS - 1);

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_DEL   = 8'h7F;

    localparam logic [1:0] REG_OUT  = 2'd0;
    localparam logic [1:0] REG_X    = 2'd1;
    localparam logic [1:0] REG_Y    = 2'd2;
    localparam logic [1:0] REG_ATTR = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUTC    = 2'd1,
        CLRLINE = 2'd2,
        CLRALL  = 2'd3
    } state_t;

    state_t           state;
    logic [ATTRW-1:0] attr;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [XW-1:0] x_clamp;
    logic [YW-1:0] y_clamp;
    logic [YW:0]   row_sum;
    logic [YW-1:0] phys_row;
    logic [YW-1:0] scroll_inc;
    logic          is_print;
    logic          ack;

    assign x_clamp = (datain > X_LIM) ? X_MAX : datain[XW-1:0];
    assign y_clamp = (datain > Y_LIM) ? Y_MAX : datain[YW-1:0];

    // Both cury and scroll are < ROWS, so their sum is < 2*ROWS and a
    // single conditional subtract gives the modulo.
    assign row_sum  = {1'b0, cury} + {1'b0, scroll};
    assign phys_row = (row_sum >= ROWS_W) ? YW'(row_sum - ROWS_W)
                                          : row_sum[YW-1:0];

    assign scroll_inc = (scroll == Y_MAX) ? '0 : scroll + YW'(1);

    // Printable: 0x20..0x7E and everything from 0x80 upwards.
    assign is_print = (datain >= CH_SPACE) && (datain != CH_DEL);

    // Only an acknowledge against an outstanding request counts.
    assign ack = fbreq && fback;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            curx   <= '0;
            cury   <= '0;
            scroll <= '0;
            attr   <= '0;
            fbreq  <= 1'b0;
            fbx    <= '0;
            fby    <= '0;
            fbchar <= '0;
            fbattr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inen) begin
                        case (addrin)
                            REG_X:    curx <= x_clamp;
                            REG_Y:    cury <= y_clamp;
                            REG_ATTR: attr <= datain[ATTRW-1:0];
                            REG_OUT: begin
                                if (is_print) begin
                                    fbx    <= curx;
                                    fby    <= phys_row;
                                    fbchar <= datain;
                                    fbattr <= attr;
                                    state  <= PUTC;
                                    busy   <= 1'b1;
                                end else if (datain == CH_CR) begin
                                    curx <= '0;
                                end else if (datain == CH_BS) begin
                                    if (curx != '0) begin
                                        curx <= curx - XW'(1);
                                    end
                                end else if (datain == CH_LF) begin
                                    curx <= '0;
                                    if (cury != Y_MAX) begin
                                        cury <= cury + YW'(1);
                                    end else begin
                                        // The new bottom physical row is
                                        // (ROWS-1 + scroll + 1) mod ROWS,
                                        // which is the current scroll.
                                        scroll <= scroll_inc;
                                        fbx    <= '0;
                                        fby    <= scroll;
                                        fbchar <= CH_SPACE;
                                        fbattr <= attr;
                                        state  <= CLRLINE;
                                        busy   <= 1'b1;
                                    end
                                end else if (datain == CH_FF) begin
                                    fbx    <= '0;
                                    fby    <= '0;
                                    fbchar <= CH_SPACE;
                                    fbattr <= attr;
                                    state  <= CLRALL;
                                    busy   <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                PUTC: begin
                    if (!fbreq) begin
                        fbreq <= 1'b1;
                    end else if (ack) begin
                        fbreq <= 1'b0;
                        if (curx != X_MAX) begin
                            curx  <= curx + XW'(1);
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            curx <= '0;
                            if (cury != Y_MAX) begin
                                cury  <= cury + YW'(1);
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                // Wrap off the bottom: scroll and blank the
                                // row that becomes the new bottom line.
                                scroll <= scroll_inc;
                                fbx    <= '0;
                                fby    <= scroll;
                                fbchar <= CH_SPACE;
                                fbattr <= attr;
                                state  <= CLRLINE;
                            end
                        end
                    end
                end

                CLRLINE: begin
                    if (!fbreq) begin
                        fbreq <= 1'b1;
                    end else if (ack) begin
                        fbreq <= 1'b0;
                        if (fbx == X_MAX) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            fbx <= fbx + XW'(1);
                        end
                    end
                end

                CLRALL: begin
                    if (!fbreq) begin
                        fbreq <= 1'b1;
                    end else if (ack) begin
                        fbreq <= 1'b0;
                        if (fbx == X_MAX) begin
                            fbx <= '0;
                            if (fby == Y_MAX) begin
                                fby    <= '0;
                                curx   <= '0;
                                cury   <= '0;
                                scroll <= '0;
                                state  <= IDLE;
                                busy   <= 1'b0;
                            end else begin
                                fby <= fby + YW'(1);
                            end
                        end else begin
                            fbx <= fbx + XW'(1);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    fbreq <= 1'b0;
                end
            endcase
        end
    end

endmodule
